delta_emitter: RTL

- Producer-side companion to the up/down delta counter.
- Accumulates per-cycle event counts into an internal pending total.
- Hands the total downstream as bounded deltas (at most 2^WIDTH-1 each) over a valid/ready interface, so a consumer counter can add one delta per accepted beat.
- Sits between event sources (perf/credit events) and a delta-consuming counter or CSR.

---
 rtl/delta_emitter.sv | 99 +++++++++
 1 files changed

// File: rtl/delta_emitter.sv
// Accumulates per-cycle event counts and hands the pending total downstream
// as bounded deltas over a valid/ready beat interface.
module delta_emitter #(
   parameter int WIDTH     = 4,
   parameter int ACC_WIDTH = 8,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic [WIDTH-1:0]     inc_i,
   input  logic [WIDTH-1:0]     threshold_i,
   input  logic                 flush_i,
   output logic [WIDTH-1:0]     delta_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [ACC_WIDTH-1:0] pending_o,
   output logic                 overflow_o
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int SW = ACC_WIDTH + 1;
   localparam logic [TW-1:0]        TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
   localparam logic [ACC_WIDTH-1:0] MAXD  = ACC_WIDTH'({WIDTH{1'b1}});

   logic [ACC_WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0]     delta_q, delta_d;
   logic                 valid_q, valid_d;
   logic                 flush_q, flush_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 overflow_q, overflow_d;

   logic [WIDTH-1:0] take, thr;
   logic [SW-1:0]    sum;
   logic             pend_nz, timeout_hit, trigger, slot_free, load, sat, drained;

   always_comb begin
      take        = (pending_q > MAXD) ? {WIDTH{1'b1}} : pending_q[WIDTH-1:0];
      thr         = (threshold_i == '0) ? WIDTH'(1) : threshold_i;
      pend_nz     = |pending_q;
      timeout_hit = (TIMEOUT != 0) && (timer_q == TLAST);
      trigger     = pend_nz && ((pending_q >= ACC_WIDTH'(thr)) || flush_q || timeout_hit);
      slot_free   = !valid_q || ready_i;
      load        = slot_free && trigger;
      sum         = {1'b0, pending_q} + (en_i ? SW'(inc_i) : '0) - (load ? SW'(take) : '0);
      sat         = sum[ACC_WIDTH];
      // flush is done once the accumulator is empty or this beat empties it
      drained     = !pend_nz || (load && (ACC_WIDTH'(take) == pending_q));

      pending_d  = sat ? '1 : sum[ACC_WIDTH-1:0];
      overflow_d = overflow_q | sat;
      flush_d    = flush_i | (flush_q & ~drained);
      timer_d    = timer_q;
      if (!pend_nz || load)    timer_d = '0;
      else if (timer_q != TLAST) timer_d = timer_q + TW'(1);
      delta_d = delta_q;
      valid_d = valid_q;
      if (load) begin
         delta_d = take;
         valid_d = 1'b1;
      end else if (slot_free) begin
         valid_d = 1'b0;
      end

      if (clear_i) begin
         pending_d  = '0;
         overflow_d = 1'b0;
         flush_d    = 1'b0;
         timer_d    = '0;
         delta_d    = '0;
         valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q  <= '0;
         delta_q    <= '0;
         valid_q    <= 1'b0;
         flush_q    <= 1'b0;
         timer_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         delta_q    <= delta_d;
         valid_q    <= valid_d;
         flush_q    <= flush_d;
         timer_q    <= timer_d;
         overflow_q <= overflow_d;
      end
   end

   assign delta_o    = delta_q;
   assign valid_o    = valid_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;

endmodule
